psg_wt_bus_master: RTL and testbench

- Downstream of the PSG wave-table bus arbiter. Takes the arbiter's grant (seln/sel) and the granted channel's fetch address, and runs one system-bus read cycle.
- Returns read data to the granted channel with a one-hot data-valid pulse.
- Drives the arbiter's ack input, which is the only point at which the arbiter may re-grant.
- Bus cycles run at the full clk rate; arbitration windows are paced by ce.

---
 rtl/psg_wt_bus_master.sv | 105 ++++++++++
 tb/tb_psg_wt_bus_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/psg_wt_bus_master.sv
// PSG wave-table bus master: turns an arbiter grant into one system-bus read
// and returns the data to the granted channel with a one-hot valid pulse.
module psg_wt_bus_master #(
  parameter int AW  = 24,
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [7:0]      req_i,
  input  logic [7:0]      sel_i,
  input  logic [2:0]      seln_i,
  input  logic [8*AW-1:0] adr_i,
  output logic            arb_ack,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [AW-1:0]   adr_o,
  input  logic            ack_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic [7:0]      dvalid,
  output logic            tout
);

  typedef enum logic [1:0] {IDLE, GRANT, BUS} state_t;

  // Terminal count of the bus watchdog; the counter starts at 0 on BUS entry.
  localparam logic [7:0] TERM = 8'(TMO - 1);

  state_t     st;
  logic [2:0] ch;
  logic [7:0] cnt;

  // Single FSM: arbitration handshake, bus cycle, watchdog, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      arb_ack <= 1'b1;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      dvalid  <= '0;
      tout    <= 1'b0;
      ch      <= '0;
      cnt     <= '0;
    end else begin
      // dvalid and tout are single-clk pulses
      dvalid <= '0;
      tout   <= 1'b0;
      case (st)
        IDLE: begin
          arb_ack <= 1'b1;
          // The arbiter re-grants on this same ce&arb_ack, so sel/seln are
          // fresh by the time GRANT looks at them.
          if (ce && |req_i) begin
            st      <= GRANT;
            arb_ack <= 1'b0;
          end
        end
        GRANT: begin
          ch <= seln_i;
          // Guard against a withdrawn request or a stale owner held by the arbiter.
          if (sel_i[seln_i] && req_i[seln_i]) begin
            st    <= BUS;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            adr_o <= adr_i[seln_i*AW +: AW];
            cnt   <= '0;
          end else begin
            st      <= IDLE;
            arb_ack <= 1'b1;
          end
        end
        BUS: begin
          // ack has priority over the watchdog terminal count
          if (ack_i) begin
            dat_o   <= dat_i;
            dvalid  <= 8'(1) << ch;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            arb_ack <= 1'b1;
            st      <= IDLE;
          end else if (cnt == TERM) begin
            tout    <= 1'b1;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            arb_ack <= 1'b1;
            st      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          st      <= IDLE;
          arb_ack <= 1'b1;
          cyc_o   <= 1'b0;
          stb_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psg_wt_bus_master.sv
// Directed bench for psg_wt_bus_master with a fixed-priority arbiter model
// and a bus slave whose ack latency is set per test.
module tb_psg_wt_bus_master;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce = 1'b0;
  logic [7:0]      req_i = '0;
  logic [7:0]      sel_i;
  logic [2:0]      seln_i;
  logic [8*AW-1:0] adr_i = '0;
  logic            arb_ack, cyc_o, stb_o, ack_i = 1'b0;
  logic [AW-1:0]   adr_o;
  logic [DW-1:0]   dat_i = 16'hBEEF, dat_o;
  logic [7:0]      dvalid;
  logic            tout;

  int vec = 0, miss = 0;
  int stbcnt = 0, phase = 0, ack_lat = 2;
  bit ack_en = 1'b1, ce_auto = 1'b1;

  psg_wt_bus_master #(.AW(AW), .DW(DW), .TMO(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .req_i(req_i), .sel_i(sel_i),
    .seln_i(seln_i), .adr_i(adr_i), .arb_ack(arb_ack), .cyc_o(cyc_o),
    .stb_o(stb_o), .adr_o(adr_o), .ack_i(ack_i), .dat_i(dat_i),
    .dat_o(dat_o), .dvalid(dvalid), .tout(tout)
  );

  always #5 clk = ~clk;

  // Fixed-priority arbiter model: channel 0 highest, re-grants on ce&ack.
  always @(posedge clk) begin
    logic [7:0] s;
    logic [2:0] n;
    if (rst) begin
      sel_i  <= '0;
      seln_i <= '0;
    end else if (ce && arb_ack) begin
      s = '0; n = seln_i;
      for (int i = 7; i >= 0; i--)
        if (req_i[i]) begin s = 8'(1) << i; n = 3'(i); end
      sel_i  <= s;
      seln_i <= n;
    end
  end

  // One clock: outputs are observed 1ns after the edge, then inputs updated.
  task automatic tick;
    @(posedge clk); #1;
    if (cyc_o) stbcnt++; else stbcnt = 0;
    ack_i = ack_en && cyc_o && (stbcnt == ack_lat);
    phase++;
    ce = ce_auto ? (phase % 4 == 0) : 1'b0;
  endtask

  task automatic wait_cyc(input string nm);
    int n = 0;
    while (!cyc_o && n < 60) begin tick; n++; end
    vec++;
    if (!cyc_o) begin miss++; $display("FAIL %s: cyc_o never rose, got 0 want 1", nm); end
  endtask

  task automatic wait_dv(input string nm);
    int n = 0;
    while (dvalid == 8'h00 && n < 60) begin tick; n++; end
    vec++;
    if (dvalid == 8'h00) begin miss++; $display("FAIL %s: dvalid never pulsed, got 00 want nonzero", nm); end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    vec++; if ({arb_ack, cyc_o, stb_o} !== 3'b100) begin miss++; $display("FAIL reset_ctl: got %b want 100", {arb_ack, cyc_o, stb_o}); end
    vec++; if ({adr_o, dat_o, dvalid, tout} !== '0) begin miss++; $display("FAIL reset_dat: adr %h dat %h dv %h tout %b want all 0", adr_o, dat_o, dvalid, tout); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat = 0;
    adr_i[2*AW +: AW] = 24'h001234; dat_i = 16'hBEEF;
    ack_en = 1'b1; ack_lat = 2; req_i = 8'h04;
    wait_cyc("basic_cyc");
    vec++; if (adr_o !== 24'h001234 || stb_o !== 1'b1) begin miss++; $display("FAIL basic_adr: got %h stb %b want 001234 stb 1", adr_o, stb_o); end
    while (dvalid == 8'h00 && lat < 20) begin tick; lat++; end
    req_i = 8'h00;
    vec++; if (lat !== 2) begin miss++; $display("FAIL basic_lat: got %0d want 2", lat); end
    vec++; if (dvalid !== 8'h04) begin miss++; $display("FAIL basic_dv: got %h want 04", dvalid); end
    vec++; if (dat_o !== 16'hBEEF) begin miss++; $display("FAIL basic_dat: got %h want beef", dat_o); end
    vec++; if (arb_ack !== 1'b1 || cyc_o !== 1'b0) begin miss++; $display("FAIL basic_ack: ack %b cyc %b want 1 0", arb_ack, cyc_o); end
    tick;
    vec++; if (dvalid !== 8'h00) begin miss++; $display("FAIL basic_pulse: got %h want 00", dvalid); end
  endtask

  task automatic test_priority;
    adr_i[0 +: AW] = 24'h0000AA; adr_i[7*AW +: AW] = 24'h7777FF;
    req_i = 8'h81;
    wait_cyc("prio_cyc0");
    vec++; if (adr_o !== 24'h0000AA) begin miss++; $display("FAIL prio_adr0: got %h want 0000aa", adr_o); end
    wait_dv("prio_dv0");
    req_i = 8'h80;
    vec++; if (dvalid !== 8'h01 || cyc_o !== 1'b0) begin miss++; $display("FAIL prio_first: dv %h cyc %b want 01 0", dvalid, cyc_o); end
    tick;
    wait_cyc("prio_cyc7");
    vec++; if (adr_o !== 24'h7777FF) begin miss++; $display("FAIL prio_adr7: got %h want 7777ff", adr_o); end
    wait_dv("prio_dv7");
    req_i = 8'h00;
    vec++; if (dvalid !== 8'h80 || cyc_o !== 1'b0) begin miss++; $display("FAIL prio_second: dv %h cyc %b want 80 0", dvalid, cyc_o); end
    tick;
  endtask

  task automatic test_withdraw;
    int n = 0;
    logic seen_cyc = 1'b0;
    logic [7:0] seen_dv = '0;
    req_i = 8'h10;
    while (arb_ack && n < 40) begin tick; n++; end
    req_i = 8'h00;
    vec++; if (arb_ack !== 1'b0) begin miss++; $display("FAIL wd_grant: arb_ack got %b want 0", arb_ack); end
    tick;
    vec++; if (arb_ack !== 1'b1 || cyc_o !== 1'b0) begin miss++; $display("FAIL wd_back: ack %b cyc %b want 1 0", arb_ack, cyc_o); end
    for (int i = 0; i < 8; i++) begin tick; seen_cyc |= cyc_o; seen_dv |= dvalid; end
    vec++; if (seen_cyc !== 1'b0 || seen_dv !== 8'h00) begin miss++; $display("FAIL wd_quiet: cyc %b dv %h want 0 00", seen_cyc, seen_dv); end
  endtask

  task automatic test_timeout;
    int hi = 0;
    adr_i[3*AW +: AW] = 24'hABCDEF;
    ack_en = 1'b0; dat_i = 16'h1111; req_i = 8'h08;
    wait_cyc("tmo_cyc");
    while (cyc_o && hi < 20) begin tick; hi++; end
    req_i = 8'h00;
    vec++; if (hi !== 8) begin miss++; $display("FAIL tmo_len: cyc_o high %0d want 8", hi); end
    vec++; if (tout !== 1'b1 || dvalid !== 8'h00) begin miss++; $display("FAIL tmo_pulse: tout %b dv %h want 1 00", tout, dvalid); end
    vec++; if (dat_o !== 16'hBEEF || arb_ack !== 1'b1) begin miss++; $display("FAIL tmo_dat: dat %h ack %b want beef 1", dat_o, arb_ack); end
    tick;
    vec++; if (tout !== 1'b0) begin miss++; $display("FAIL tmo_once: tout got %b want 0", tout); end
    // ack on the terminal clock beats the watchdog
    ack_en = 1'b1; ack_lat = 8; dat_i = 16'h2222; req_i = 8'h08; hi = 0;
    wait_cyc("tmo2_cyc");
    while (cyc_o && hi < 20) begin tick; hi++; end
    req_i = 8'h00;
    vec++; if (hi !== 8) begin miss++; $display("FAIL tmo2_len: cyc_o high %0d want 8", hi); end
    vec++; if (dvalid !== 8'h08 || tout !== 1'b0) begin miss++; $display("FAIL tmo2_win: dv %h tout %b want 08 0", dvalid, tout); end
    vec++; if (dat_o !== 16'h2222) begin miss++; $display("FAIL tmo2_dat: got %h want 2222", dat_o); end
    tick;
  endtask

  task automatic test_rst_mid;
    ack_en = 1'b0; req_i = 8'h20; adr_i[5*AW +: AW] = 24'h555555;
    wait_cyc("rst_cyc");
    tick; tick; tick;
    vec++; if (cyc_o !== 1'b1) begin miss++; $display("FAIL rst_inbus: cyc got %b want 1", cyc_o); end
    rst = 1'b1; tick;
    vec++; if ({cyc_o, stb_o, arb_ack} !== 3'b001) begin miss++; $display("FAIL rst_ctl: got %b want 001", {cyc_o, stb_o, arb_ack}); end
    vec++; if ({dat_o, dvalid, tout, adr_o} !== '0) begin miss++; $display("FAIL rst_dat: dat %h dv %h tout %b adr %h want 0", dat_o, dvalid, tout, adr_o); end
    rst = 1'b0; ack_en = 1'b1; ack_lat = 2; dat_i = 16'h3333;
    wait_dv("rst_resume");
    req_i = 8'h00;
    vec++; if (dvalid !== 8'h20 || dat_o !== 16'h3333) begin miss++; $display("FAIL rst_resume_dat: dv %h dat %h want 20 3333", dvalid, dat_o); end
    tick;
  endtask

  task automatic test_ce_gate;
    logic seen_cyc = 1'b0, seen_nack = 1'b0;
    ce_auto = 1'b0; tick; tick;
    req_i = 8'h02; adr_i[1*AW +: AW] = 24'h111111; dat_i = 16'h4444;
    for (int i = 0; i < 20; i++) begin tick; seen_cyc |= cyc_o; seen_nack |= ~arb_ack; end
    vec++; if (seen_cyc !== 1'b0 || seen_nack !== 1'b0) begin miss++; $display("FAIL ce_idle: cyc %b nack %b want 0 0", seen_cyc, seen_nack); end
    ce = 1'b1; tick;
    vec++; if (arb_ack !== 1'b0 || cyc_o !== 1'b0) begin miss++; $display("FAIL ce_grant: ack %b cyc %b want 0 0", arb_ack, cyc_o); end
    tick;
    vec++; if (cyc_o !== 1'b1 || adr_o !== 24'h111111) begin miss++; $display("FAIL ce_bus: cyc %b adr %h want 1 111111", cyc_o, adr_o); end
    wait_dv("ce_dv");
    req_i = 8'h00;
    vec++; if (dvalid !== 8'h02 || dat_o !== 16'h4444) begin miss++; $display("FAIL ce_dat: dv %h dat %h want 02 4444", dvalid, dat_o); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_withdraw;
    test_timeout;
    test_rst_mid;
    test_ce_gate;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
